// File: rtl/otp_entry_checker.sv
// ============================================================================
//  Module      : otp_entry_checker
//  Description : One-time-password session controller. Captures an LFSR code,
//                collects keypad digits, and issues grant, deny or lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otp_entry_checker #(
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] otp_code,
  input  logic        otp_latch,
  input  logic [3:0]  user_in,
  input  logic        user_latch,
  output logic        grant,
  output logic        deny,
  output logic        expired,
  output logic        locked,
  output logic [2:0]  digit_cnt,
  output logic [3:0]  last_digit,
  output logic [1:0]  tries,
  output logic [2:0]  state_o
);

  localparam int c_tmr_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_lock_w = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_CYCLES - 1);
  localparam logic [2:0]          c_digits    = 3'(DIGITS);
  localparam logic [1:0]          c_max_tries = 2'(MAX_TRIES);
  // Only the low DIGITS nibbles of the code take part in the comparison.
  localparam logic [15:0]         c_mask      = 16'((32'h1 << (4 * DIGITS)) - 32'h1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_CHECK  = 3'd2,
    S_GRANT  = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_otp_s1, r_otp_s2, r_otp_s2d;
  logic                 r_usr_s1, r_usr_s2, r_usr_s2d;
  logic [3:0]           r_uin_s1, r_uin_s2;
  logic [15:0]          r_otp_reg;
  logic [15:0]          r_entry;
  logic [c_tmr_w-1:0]   r_timer;
  logic [c_lock_w-1:0]  r_lock_cnt;
  logic                 r_grant, r_deny, r_expired, r_locked;
  logic [2:0]           r_digit_cnt;
  logic [3:0]           r_last_digit;
  logic [1:0]           r_tries;

  logic                 w_otp_press;
  logic                 w_usr_press;
  logic                 w_match;
  logic [2:0]           w_cnt_next;
  logic [1:0]           w_tries_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_otp_s1  <= 1'b0;
      r_otp_s2  <= 1'b0;
      r_otp_s2d <= 1'b0;
      r_usr_s1  <= 1'b0;
      r_usr_s2  <= 1'b0;
      r_usr_s2d <= 1'b0;
      r_uin_s1  <= 4'h0;
      r_uin_s2  <= 4'h0;
    end else begin
      r_otp_s1  <= otp_latch;
      r_otp_s2  <= r_otp_s1;
      r_otp_s2d <= r_otp_s2;
      r_usr_s1  <= user_latch;
      r_usr_s2  <= r_usr_s1;
      r_usr_s2d <= r_usr_s2;
      r_uin_s1  <= user_in;
      r_uin_s2  <= r_uin_s1;
    end
  end

  assign w_otp_press  = r_otp_s2 & ~r_otp_s2d;
  assign w_usr_press  = r_usr_s2 & ~r_usr_s2d;
  assign w_match      = ((r_entry ^ r_otp_reg) & c_mask) == 16'h0000;
  assign w_cnt_next   = r_digit_cnt + 3'd1;
  assign w_tries_next = (r_tries < c_max_tries) ? r_tries + 2'd1 : r_tries;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_otp_reg    <= 16'h0000;
      r_entry      <= 16'h0000;
      r_timer      <= '0;
      r_lock_cnt   <= '0;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
      r_expired    <= 1'b0;
      r_locked     <= 1'b0;
      r_digit_cnt  <= 3'd0;
      r_last_digit <= 4'h0;
      r_tries      <= 2'd0;
    end else begin
      r_deny    <= 1'b0;
      r_expired <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_otp_press) begin
            r_otp_reg   <= otp_code;
            r_entry     <= 16'h0000;
            r_digit_cnt <= 3'd0;
            r_timer     <= '0;
            r_state     <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          // A fresh capture wins over a digit arriving in the same cycle.
          if (w_otp_press) begin
            r_otp_reg   <= otp_code;
            r_entry     <= 16'h0000;
            r_digit_cnt <= 3'd0;
            r_timer     <= '0;
          end else if (w_usr_press) begin
            r_entry      <= {r_entry[11:0], r_uin_s2};
            r_last_digit <= r_uin_s2;
            r_digit_cnt  <= w_cnt_next;
            r_timer      <= '0;
            if (w_cnt_next == c_digits) begin
              r_state <= S_CHECK;
            end
          end else if (r_timer == c_tmr_last) begin
            r_deny      <= 1'b1;
            r_expired   <= 1'b1;
            r_digit_cnt <= 3'd0;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_CHECK: begin
          if (w_match) begin
            r_tries <= 2'd0;
            r_grant <= 1'b1;
            r_state <= S_GRANT;
          end else begin
            r_tries <= w_tries_next;
            r_deny  <= 1'b1;
            if (w_tries_next == c_max_tries) begin
              r_locked   <= 1'b1;
              r_lock_cnt <= '0;
              r_state    <= S_LOCKED;
            end else begin
              r_entry     <= 16'h0000;
              r_digit_cnt <= 3'd0;
              r_timer     <= '0;
              r_state     <= S_ENTRY;
            end
          end
        end

        S_GRANT: begin
          if (w_otp_press) begin
            r_otp_reg   <= otp_code;
            r_entry     <= 16'h0000;
            r_digit_cnt <= 3'd0;
            r_timer     <= '0;
            r_grant     <= 1'b0;
            r_state     <= S_ENTRY;
          end
        end

        S_LOCKED: begin
          if (r_lock_cnt == c_lock_last) begin
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_tries     <= 2'd0;
            r_digit_cnt <= 3'd0;
            r_state     <= S_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end

        default: begin
          r_grant  <= 1'b0;
          r_locked <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign deny       = r_deny;
  assign expired    = r_expired;
  assign locked     = r_locked;
  assign digit_cnt  = r_digit_cnt;
  assign last_digit = r_last_digit;
  assign tries      = r_tries;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_otp_entry_checker.sv
// ============================================================================
//  Module      : tb_otp_entry_checker
//  Description : Scoreboard bench for otp_entry_checker; each observable
//                state/count change or pulse is matched against a queued value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_otp_entry_checker;

  localparam int DIGITS         = 4;
  localparam int MAX_TRIES      = 3;
  localparam int LOCK_CYCLES    = 16;
  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] otp_code;
  logic        otp_latch;
  logic [3:0]  user_in;
  logic        user_latch;
  logic        grant, deny, expired, locked;
  logic [2:0]  digit_cnt;
  logic [3:0]  last_digit;
  logic [1:0]  tries;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  otp_entry_checker #(
    .DIGITS         (DIGITS),
    .MAX_TRIES      (MAX_TRIES),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .otp_code   (otp_code),
    .otp_latch  (otp_latch),
    .user_in    (user_in),
    .user_latch (user_latch),
    .grant      (grant),
    .deny       (deny),
    .expired    (expired),
    .locked     (locked),
    .digit_cnt  (digit_cnt),
    .last_digit (last_digit),
    .tries      (tries),
    .state_o    (state_o)
  );

  typedef struct {
    logic [2:0] st;
    logic [2:0] cnt;
    logic [3:0] last;
    logic [1:0] tries;
    logic       g, d, x, l;
    int         dly;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  int         cyc      = 0;
  int         last_cyc = 0;
  logic [2:0] p_state  = 3'd0;
  logic [2:0] p_cnt    = 3'd0;
  logic [3:0] exp_last = 4'h0;
  logic [1:0] exp_tries = 2'd0;

  // An output event is any state or digit-count change, or a deny/expired pulse.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && (state_o != p_state || digit_cnt != p_cnt || deny || expired)) begin
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got st=%0d cnt=%0d deny=%0b expired=%0b at cycle %0d, required no event",
                 state_o, digit_cnt, deny, expired, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (state_o !== mon_e.st || digit_cnt !== mon_e.cnt || last_digit !== mon_e.last ||
            tries !== mon_e.tries || grant !== mon_e.g || deny !== mon_e.d ||
            expired !== mon_e.x || locked !== mon_e.l ||
            (mon_e.dly >= 0 && (cyc - last_cyc) != mon_e.dly)) begin
          n_fail++;
          $display("FAIL event: got st=%0d cnt=%0d last=%h tries=%0d g=%0b d=%0b x=%0b l=%0b gap=%0d, required st=%0d cnt=%0d last=%h tries=%0d g=%0b d=%0b x=%0b l=%0b gap=%0d",
                   state_o, digit_cnt, last_digit, tries, grant, deny, expired, locked, cyc - last_cyc,
                   mon_e.st, mon_e.cnt, mon_e.last, mon_e.tries, mon_e.g, mon_e.d, mon_e.x, mon_e.l, mon_e.dly);
        end
      end
      last_cyc = cyc;
    end
    p_state = state_o;
    p_cnt   = digit_cnt;
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 5000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [2:0] st, input logic [2:0] cnt, input logic [3:0] last,
                          input logic [1:0] tr, input logic g, input logic d, input logic x,
                          input logic l, input int dly);
    exp_t e;
    e.st = st; e.cnt = cnt; e.last = last; e.tries = tr;
    e.g = g; e.d = d; e.x = x; e.l = l; e.dly = dly;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic press(input bit is_otp, input bit is_usr, input logic [15:0] code, input logic [3:0] d);
    @(posedge clk); #1;
    otp_code   = code;
    user_in    = d;
    otp_latch  = is_otp;
    user_latch = is_usr;
    repeat (3) @(posedge clk);
    #1;
    otp_latch  = 1'b0;
    user_latch = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic capture(input logic [15:0] code);
    push_exp(3'd1, 3'd0, exp_last, exp_tries, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    press(1'b1, 1'b0, code, 4'h0);
  endtask

  task automatic digit(input logic [3:0] d, input logic [2:0] cnt);
    exp_last = d;
    push_exp(3'd1, cnt, d, exp_tries, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    press(1'b0, 1'b1, otp_code, d);
  endtask

  // res: 0 = grant, 1 = deny back to ENTRY, 2 = deny into LOCKED
  task automatic enter_code(input logic [15:0] code, input int res, input logic [1:0] tries_after);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = code[15 - 4*i -: 4];
      exp_last = d;
      if (i < 3) begin
        push_exp(3'd1, 3'(i + 1), d, exp_tries, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      end else begin
        push_exp(3'd2, 3'd4, d, exp_tries, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        exp_tries = tries_after;
        if (res == 0) begin
          push_exp(3'd3, 3'd4, d, tries_after, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        end else if (res == 1) begin
          push_exp(3'd1, 3'd0, d, tries_after, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        end else begin
          push_exp(3'd4, 3'd4, d, tries_after, 1'b0, 1'b1, 1'b0, 1'b1, 1);
          push_exp(3'd0, 3'd0, d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, LOCK_CYCLES);
          exp_tries = 2'd0;
        end
      end
      press(1'b0, 1'b1, otp_code, d);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; otp_code = 16'h0; otp_latch = 1'b0; user_latch = 1'b0; user_in = 4'h0;
    #1;
    otp_code = 16'($urandom); otp_latch = 1'($urandom);
    user_latch = 1'($urandom); user_in = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {15'h0, grant}, 16'h0);
    chk("rst_deny", {15'h0, deny}, 16'h0);
    chk("rst_expired", {15'h0, expired}, 16'h0);
    chk("rst_locked", {15'h0, locked}, 16'h0);
    chk("rst_digit_cnt", {13'h0, digit_cnt}, 16'h0);
    chk("rst_last_digit", {12'h0, last_digit}, 16'h0);
    chk("rst_tries", {14'h0, tries}, 16'h0);
    chk("rst_state", {13'h0, state_o}, 16'h0);
    otp_latch = 1'b0; user_latch = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    // Digit in IDLE is ignored; then a correct entry.
    press(1'b0, 1'b1, otp_code, 4'h9);
    capture(16'hA5C3);
    enter_code(16'hA5C3, 0, 2'd0);
    press(1'b0, 1'b1, otp_code, 4'h9);
    wait_drain(20);

    // Wrong code once, then the right one.
    capture(16'hA5C3);
    enter_code(16'hA5C2, 1, 2'd1);
    enter_code(16'hA5C3, 0, 2'd0);
    wait_drain(20);

    // Three wrong codes lock the block; presses during lockout do nothing.
    capture(16'hA5C3);
    enter_code(16'h0000, 1, 2'd1);
    enter_code(16'h0000, 1, 2'd2);
    enter_code(16'h0000, 2, 2'd3);
    press(1'b1, 1'b0, 16'hA5C3, 4'h0);
    press(1'b0, 1'b1, otp_code, 4'h5);
    wait_drain(40);

    // Two digits then silence until the timeout fires.
    capture(16'h5555);
    digit(4'h1, 3'd1);
    digit(4'h2, 3'd2);
    push_exp(3'd0, 3'd0, 4'h2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, TIMEOUT_CYCLES);
    wait_drain(200);

    // Simultaneous presses: capture wins, the digit is dropped.
    capture(16'h5555);
    digit(4'h1, 3'd1);
    digit(4'h2, 3'd2);
    push_exp(3'd1, 3'd0, 4'h2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    press(1'b1, 1'b1, 16'h1234, 4'h7);
    enter_code(16'h1234, 0, 2'd0);
    wait_drain(20);

    // Reset in the middle of an entry.
    capture(16'hBEEF);
    digit(4'hB, 3'd1);
    wait_drain(20);
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_state", {13'h0, state_o}, 16'h0);
    chk("midrst_digit_cnt", {13'h0, digit_cnt}, 16'h0);
    chk("midrst_last_digit", {12'h0, last_digit}, 16'h0);
    chk("midrst_grant", {15'h0, grant}, 16'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    chk("scoreboard_empty", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
